// File: rtl/onehot_encoder_pipe_if.sv
// Handshake bundle for onehot_encoder_pipe: request side, result side and error counter.
`timescale 1ns/1ps
interface onehot_encoder_pipe_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] d;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [1:0]   out_err;
  logic         err_clr;
  logic [15:0]  err_cnt;

  modport master (
    output in_valid, d, mode, out_ready, err_clr,
    input  in_ready, out_valid, y, out_err, err_cnt
  );

  modport slave (
    input  in_valid, d, mode, out_ready, err_clr,
    output in_ready, out_valid, y, out_err, err_cnt
  );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// N-to-log2(N) encoder (strict/LSB/MSB/round-robin), 1-cycle registered result; ONEHOT_ENC_ERR_CNT_EN adds err counter.
// Backpressure: single output register, in_ready = rst_n && (!out_valid || out_ready).
`timescale 1ns/1ps
module onehot_encoder_pipe #(
  parameter int N = 8
) (
  input logic clk,
  input logic rst_n,
  onehot_encoder_pipe_if.slave bus
);
  localparam int W = $clog2(N);

  localparam logic [1:0] MODE_STRICT = 2'b00;
  localparam logic [1:0] MODE_LSB    = 2'b01;
  localparam logic [1:0] MODE_MSB    = 2'b10;
  localparam logic [1:0] MODE_RR     = 2'b11;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ZERO  = 2'b01;
  localparam logic [1:0] ERR_MULTI = 2'b10;

  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [W-1:0] LAST_IX = W'(N - 1);

  logic         out_valid_q;
  logic [W-1:0] y_q;
  logic [1:0]   err_q;
  logic [W-1:0] ptr;

  logic         in_xfer;
  logic         zero;
  logic         multi;
  logic [W-1:0] lsb_idx;
  logic [W-1:0] msb_idx;
  logic [W-1:0] up_idx;
  logic         up_hit;
  logic [W-1:0] rr_idx;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] res_y;
  logic [1:0]   res_err;

  assign bus.in_ready  = rst_n && (!out_valid_q || bus.out_ready);
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.out_err   = err_q;

  assign zero  = ~|bus.d;
  assign multi = |(bus.d & (bus.d - ONE));

  always_comb begin
    lsb_idx = '0;
    msb_idx = '0;
    up_idx  = '0;
    up_hit  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.d[i]) begin
        lsb_idx = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bus.d[i]) begin
        msb_idx = W'(i);
      end
    end
    // Lowest set bit at or above ptr; if none, the search wraps to the lowest set bit overall.
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.d[i] && (i >= int'(ptr))) begin
        up_idx = W'(i);
        up_hit = 1'b1;
      end
    end
  end

  assign rr_idx  = up_hit ? up_idx : lsb_idx;
  assign ptr_nxt = (rr_idx == LAST_IX) ? '0 : rr_idx + 1'b1;

  always_comb begin
    res_y   = '0;
    res_err = ERR_OK;
    if (zero) begin
      res_err = ERR_ZERO;
    end else begin
      case (bus.mode)
        MODE_STRICT: begin
          if (multi) begin
            res_err = ERR_MULTI;
          end else begin
            res_y = lsb_idx;
          end
        end
        MODE_LSB: begin
          res_y   = lsb_idx;
          res_err = multi ? ERR_MULTI : ERR_OK;
        end
        MODE_MSB: begin
          res_y   = msb_idx;
          res_err = multi ? ERR_MULTI : ERR_OK;
        end
        default: begin
          res_y = rr_idx;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      err_q       <= ERR_OK;
      ptr         <= '0;
    end else begin
      if (in_xfer) begin
        out_valid_q <= 1'b1;
        y_q         <= res_y;
        err_q       <= res_err;
        if ((bus.mode == MODE_RR) && !zero) begin
          ptr <= ptr_nxt;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ONEHOT_ENC_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end else if (in_xfer && (res_err != ERR_OK) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_cnt    = 16'h0000;
`endif

endmodule
